// File: rtl/axis_gap_pkg.sv
// Shared types and constants for the AXI-Stream inter-packet gap policer.
package axis_gap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int SAT_INC       = 1;
  localparam int DEFAULT_GAP_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once full.
module sat_counter
  import axis_gap_pkg::*;
#(
  parameter int WIDTH = DEFAULT_GAP_W
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(SAT_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/axis_gap_policer.sv
// Measures idle cycles between AXI-Stream packets and flags gaps shorter than MIN_GAP.
// Define AXIS_GAP_POLICER_DROP_EN to discard violating packets instead of only reporting them.
module axis_gap_policer
  import axis_gap_pkg::*;
#(
  parameter int AXIS_BYTES = 1,
  parameter int MIN_GAP    = 1,
  parameter int GAP_WIDTH  = DEFAULT_GAP_W
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  output logic [GAP_WIDTH-1:0]    gap_o,
  output logic                    gap_valid_o,
  output logic                    violation_o,
  output logic [GAP_WIDTH-1:0]    viol_count_o
);

  localparam logic [GAP_WIDTH-1:0] MinGapW = GAP_WIDTH'(MIN_GAP);

  state_e               state_d, state_q;
  logic                 seen_pkt_d, seen_pkt_q;
  logic [GAP_WIDTH-1:0] gap_d, gap_q;
  logic                 gap_valid_d, gap_valid_q;
  logic                 violation_d, violation_q;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic                 eval;
  logic                 viol;
  logic                 drop;
  logic                 acc_last;

  always_comb begin
    state_d       = state_q;
    axis_i_tready = 1'b0;
    axis_o_tvalid = 1'b0;
    drop          = 1'b0;
    // The first valid beat seen while idle closes the gap measurement.
    eval = (state_q == ST_IDLE) && axis_i_tvalid;
    viol = eval && seen_pkt_q && (gap_cnt < MinGapW);
`ifdef AXIS_GAP_POLICER_DROP_EN
    drop = (state_q == ST_DROP) || viol;
`endif
    if (sresetn) begin
      axis_o_tvalid = axis_i_tvalid && !drop;
      axis_i_tready = drop ? 1'b1 : axis_o_tready;
    end
    acc_last = axis_i_tvalid && axis_i_tready && axis_i_tlast;

    // A stalled first beat moves on to PASS so tvalid is never withdrawn.
    case (state_q)
      ST_IDLE: if (eval && !acc_last) state_d = drop ? ST_DROP : ST_PASS;
      ST_PASS,
      ST_DROP: if (acc_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    seen_pkt_d  = seen_pkt_q || acc_last;
    gap_valid_d = eval && seen_pkt_q;
    violation_d = viol;
    gap_d       = (eval && seen_pkt_q) ? gap_cnt : gap_q;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q     <= ST_IDLE;
      seen_pkt_q  <= 1'b0;
      gap_q       <= '0;
      gap_valid_q <= 1'b0;
      violation_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_pkt_q  <= seen_pkt_d;
      gap_q       <= gap_d;
      gap_valid_q <= gap_valid_d;
      violation_q <= violation_d;
    end
  end

  sat_counter #(.WIDTH(GAP_WIDTH)) u_gap_cnt (
    .clk     (clk),
    .sresetn (sresetn),
    .clr     (acc_last),
    .en      ((state_q == ST_IDLE) && !axis_i_tvalid),
    .count_o (gap_cnt)
  );

  sat_counter #(.WIDTH(GAP_WIDTH)) u_viol_cnt (
    .clk     (clk),
    .sresetn (sresetn),
    .clr     (1'b0),
    .en      (viol),
    .count_o (viol_count_o)
  );

  assign axis_o_tdata = axis_i_tdata;
  assign axis_o_tlast = axis_i_tlast;
  assign gap_o        = gap_q;
  assign gap_valid_o  = gap_valid_q;
  assign violation_o  = violation_q;

endmodule

// File: tb/tb_axis_gap_policer.sv
// Scoreboard bench for axis_gap_policer with MIN_GAP=4, GAP_WIDTH=16.
module tb_axis_gap_policer;

  localparam int MIN_GAP = 4;
  localparam int GW      = 16;
`ifdef AXIS_GAP_POLICER_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct packed {
    logic [GW-1:0] gap;
    logic          viol;
    logic [GW-1:0] cnt;
  } gap_ev_t;

  logic          clk = 1'b0;
  logic          sresetn;
  logic          axis_i_tready;
  logic          axis_i_tvalid;
  logic          axis_i_tlast;
  logic [7:0]    axis_i_tdata;
  logic          axis_o_tready;
  logic          axis_o_tvalid;
  logic          axis_o_tlast;
  logic [7:0]    axis_o_tdata;
  logic [GW-1:0] gap_o;
  logic          gap_valid_o;
  logic          violation_o;
  logic [GW-1:0] viol_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t   beat_q[$];
  gap_ev_t ev_q[$];
  bit      seen = 1'b0;
  int      viol_cnt = 0;

  always #5 clk = ~clk;

  axis_gap_policer #(
    .AXIS_BYTES (1),
    .MIN_GAP    (MIN_GAP),
    .GAP_WIDTH  (GW)
  ) dut (
    .clk           (clk),
    .sresetn       (sresetn),
    .axis_i_tready (axis_i_tready),
    .axis_i_tvalid (axis_i_tvalid),
    .axis_i_tlast  (axis_i_tlast),
    .axis_i_tdata  (axis_i_tdata),
    .axis_o_tready (axis_o_tready),
    .axis_o_tvalid (axis_o_tvalid),
    .axis_o_tlast  (axis_o_tlast),
    .axis_o_tdata  (axis_o_tdata),
    .gap_o         (gap_o),
    .gap_valid_o   (gap_valid_o),
    .violation_o   (violation_o),
    .viol_count_o  (viol_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: pops expected beats and gap reports as the DUT produces them.
  always @(negedge clk) begin
    beat_t   b;
    gap_ev_t e;
    if (axis_o_tvalid && axis_o_tready) begin
      if (beat_q.size() == 0) begin
        check_eq("unexpected_beat", 1, 0);
      end else begin
        b = beat_q.pop_front();
        check_eq("beat_data", {24'd0, axis_o_tdata}, {24'd0, b.data});
        check_eq("beat_last", {31'd0, axis_o_tlast}, {31'd0, b.last});
      end
    end
    if (gap_valid_o) begin
      if (ev_q.size() == 0) begin
        check_eq("unexpected_gap_valid", 1, 0);
      end else begin
        e = ev_q.pop_front();
        check_eq("gap_o", {16'd0, gap_o}, {16'd0, e.gap});
        check_eq("violation_o", {31'd0, violation_o}, {31'd0, e.viol});
        check_eq("viol_count_o", {16'd0, viol_count_o}, {16'd0, e.cnt});
      end
    end else if (violation_o) begin
      check_eq("violation_without_gap_valid", 1, 0);
    end
  end

  task automatic idle(input int n);
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one packet after `gap` idle cycles; `cut` stops before the tlast beat.
  task automatic send_pkt(input int nbeats, input int gap, input bit stall, input bit cut);
    bit v;
    bit dropped;
    int n;
    gap_ev_t e;
    beat_t b;
    idle(gap);
    v = seen && (gap < MIN_GAP);
    if (v && viol_cnt < 65535) viol_cnt++;
    if (seen) begin
      e.gap  = gap[GW-1:0];
      e.viol = v;
      e.cnt  = viol_cnt[GW-1:0];
      ev_q.push_back(e);
    end
    dropped = DROP_EN && v;
    for (int i = 0; i < nbeats; i++) begin
      if (cut && i == nbeats - 1) return;
      b.data = 8'($urandom);
      b.last = (i == nbeats - 1);
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = b.data;
      axis_i_tlast  = b.last;
      if (!dropped) beat_q.push_back(b);
      if (stall && i == 0) begin
        axis_o_tready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_eq("stall_tvalid", {31'd0, axis_o_tvalid}, 32'd1);
          check_eq("stall_tdata", {24'd0, axis_o_tdata}, {24'd0, b.data});
          @(posedge clk);
          #1;
        end
        axis_o_tready = 1'b1;
      end
      n = 0;
      @(negedge clk);
      while (!axis_i_tready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check_eq("accept_timeout", 0, 1);
      if (dropped) check_eq("drop_tvalid", {31'd0, axis_o_tvalid}, 32'd0);
      @(posedge clk);
      #1;
    end
    seen = 1'b1;
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    sresetn       = 1'b0;
    axis_i_tvalid = 1'b1;
    axis_i_tlast  = 1'b1;
    axis_o_tready = 1'b1;
    seen          = 1'b0;
    viol_cnt      = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_eq("rst_i_tready", {31'd0, axis_i_tready}, 32'd0);
    check_eq("rst_o_tvalid", {31'd0, axis_o_tvalid}, 32'd0);
    check_eq("rst_gap_o", {16'd0, gap_o}, 32'd0);
    check_eq("rst_gap_valid", {31'd0, gap_valid_o}, 32'd0);
    check_eq("rst_violation", {31'd0, violation_o}, 32'd0);
    check_eq("rst_viol_count", {16'd0, viol_count_o}, 32'd0);
    @(posedge clk);
    #1;
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    sresetn       = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_i_tdata = 8'h00;
    do_reset();
    send_pkt(3, 2, 1'b0, 1'b0);  // first packet: passes, no gap report
    send_pkt(3, 6, 1'b0, 1'b0);  // gap 6: clean
    send_pkt(3, 2, 1'b0, 1'b0);  // gap 2: violation (dropped with drop enable)
    send_pkt(3, 5, 1'b0, 1'b0);  // gap 5: clean
    send_pkt(2, 4, 1'b1, 1'b0);  // gap == MIN_GAP, first beat stalled 3 cycles
    send_pkt(1, 3, 1'b0, 1'b0);  // single-beat violation
    send_pkt(2, 0, 1'b0, 1'b0);  // back-to-back violation
    send_pkt(3, 6, 1'b0, 1'b1);  // abandoned by reset mid-packet
    do_reset();
    send_pkt(3, 1, 1'b0, 1'b0);  // gap 1 after reset: no report
    send_pkt(2, 1, 1'b0, 1'b0);  // gap 1 with seen_pkt set: violation
    send_pkt(3, 6, 1'b0, 1'b0);
    idle(4);
    check_eq("beats_outstanding", beat_q.size(), 0);
    check_eq("gap_reports_outstanding", ev_q.size(), 0);
    check_eq("final_viol_count", {16'd0, viol_count_o}, viol_cnt);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_gap_policer.md
AXIS_GAP_POLICER -- requirements
Module: axis_gap_policer

Interface
REQ-001 SHALL have parameter AXIS_BYTES, default 1, tdata width in bytes.
REQ-002 SHALL have parameter MIN_GAP, default 1, minimum idle cycles required between packets; legal range 0..2^GAP_WIDTH-1.
REQ-003 SHALL have parameter GAP_WIDTH, default 16, width of the gap counter and the violation counter.
REQ-004 SHALL have port clk  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port sresetn  in  1  reset, synchronous and active-low.
REQ-006 SHALL have ports axis_i_tready out 1, axis_i_tvalid in 1, axis_i_tlast in 1, axis_i_tdata in AXIS_BYTES*8: the upstream slave stream.
REQ-007 SHALL have ports axis_o_tready in 1, axis_o_tvalid out 1, axis_o_tlast out 1, axis_o_tdata out AXIS_BYTES*8: the downstream master stream.
REQ-008 SHALL have port gap_o  out  GAP_WIDTH  the last measured inter-packet gap.
REQ-009 SHALL have port gap_valid_o  out  1  one-cycle pulse when gap_o updates.
REQ-010 SHALL have port violation_o  out  1  one-cycle pulse, coincident with gap_valid_o, when the measured gap < MIN_GAP.
REQ-011 SHALL have port viol_count_o  out  GAP_WIDTH  saturating count of violations since reset.

Function
REQ-012 SHALL implement states IDLE (between packets, counting), PASS (forwarding a packet) and DROP (discarding a packet; reachable only when the macro is enabled).
REQ-013 SHALL pass axis_o_tdata and axis_o_tlast combinationally from the input, with zero latency.
REQ-014 In IDLE and PASS, with no drop decision, SHALL drive axis_o_tvalid=axis_i_tvalid and axis_i_tready=axis_o_tready.
REQ-015 In IDLE, the gap counter SHALL increment each cycle that axis_i_tvalid=0, and SHALL saturate at all-ones.
REQ-016 The gap counter SHALL clear to 0 on the cycle after any accepted tlast beat.
REQ-017 The first IDLE cycle with axis_i_tvalid=1 is the evaluation cycle; gap = counter value in that cycle, and violation = seen_pkt && gap < MIN_GAP.
REQ-018 The cycle after the evaluation cycle, SHALL register gap_o=gap and pulse gap_valid_o=1 and violation_o=violation; these SHALL be suppressed when seen_pkt=0.
REQ-019 seen_pkt SHALL set on the first accepted tlast after reset; the first packet after reset SHALL never be a violation.
REQ-020 From the evaluation cycle, SHALL go to IDLE if a tlast beat is accepted that cycle, otherwise to PASS (or to DROP per REQ-028).
REQ-021 Stalled first beat: if it is not accepted in the evaluation cycle, SHALL move to PASS and continue presenting; tvalid SHALL NOT be withdrawn downstream.
REQ-022 PASS SHALL return to IDLE on an accepted tlast beat.
REQ-023 viol_count_o SHALL increment by 1 per violation and SHALL hold at all-ones when saturated.
REQ-024 MIN_GAP=0 SHALL never flag a violation.

Reset
REQ-025 While sresetn=0 at a clock edge: state=IDLE, gap counter=0, seen_pkt=0, gap_o=0, gap_valid_o=0, violation_o=0, viol_count_o=0.
REQ-026 While sresetn=0, axis_i_tready=0 and axis_o_tvalid=0 combinationally.
REQ-027 Reset mid-packet SHALL abandon the packet; no tlast is synthesised downstream.

Configuration
REQ-028 With AXIS_GAP_POLICER_DROP_EN defined, a violating packet SHALL be discarded:
- in the evaluation cycle and in DROP: axis_o_tvalid=0, axis_i_tready=1;
- exit to IDLE on the accepted tlast, which clears the gap counter.
REQ-029 Without AXIS_GAP_POLICER_DROP_EN, the DROP state SHALL be absent, violations are reported only, and all packets pass.

Structure
REQ-030 Package axis_gap_pkg SHALL hold the state enum typedef (IDLE/PASS/DROP) and the saturating-increment width constants.
REQ-031 Sub-module sat_counter (width parameter, clear, enable, saturate at all-ones) SHALL be instantiated for the gap counter and for viol_count_o.

Verification (MIN_GAP=4, GAP_WIDTH=16)
REQ-032 First packet of 3 beats after reset, with axis_o_tready=1 -> passes unchanged; no gap_valid_o pulse.
REQ-033 Two packets separated by 6 idle cycles -> gap_o=6, gap_valid_o pulse, violation_o=0, viol_count_o=0.
REQ-034 Gap of 2, macro off -> second packet passes; violation_o pulse; viol_count_o=1.
REQ-035 Gap of 2, macro on -> the 3-beat second packet is consumed with axis_o_tvalid=0 for all beats; a following packet after gap 5 passes.
REQ-036 First beat stalled 3 cycles by axis_o_tready=0 -> tdata held and tvalid continuous; one gap_valid_o pulse only.
REQ-037 Reset asserted mid-packet, then gap 1 -> no violation, because seen_pkt has been cleared.
